// File: rtl/uart_rx_param.sv
// rtl/uart_rx_param.sv - oversampling UART receiver with holding register and RTS; UART_RX_MAJORITY_EN enables 2-of-3 bit voting
module uart_rx_param #(
    parameter int CLK_FREQ   = 12000000,
    parameter int BAUD_RATE  = 115200,
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 valid,
    input  logic                 ready,
    output logic                 rts,
    output logic                 busy,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun_err
);

    localparam int DIV_CALC = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
    localparam int DIV      = (DIV_CALC < 1) ? 1 : DIV_CALC;
    localparam int DIV_W    = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int OS_W     = $clog2(OVERSAMPLE);

    localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(DIV - 1);
    localparam logic [OS_W-1:0]  OS_LAST    = OS_W'(OVERSAMPLE - 1);
    localparam logic [OS_W-1:0]  SAMPLE_IDX = OS_W'(OVERSAMPLE / 2);
    localparam logic [3:0]       LAST_DATA  = 4'(DATA_BITS - 1);
    localparam logic [3:0]       LAST_STOP  = 4'(STOP_BITS - 1);
    localparam logic             PAR_ODD    = (PARITY == 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;

    logic                 rx_meta;
    logic                 rx_s;
    logic                 rx_prev;
    logic [DIV_W-1:0]     div_cnt;
    logic [OS_W-1:0]      os_cnt;
    logic [2:0]           state;
    logic [3:0]           bit_cnt;
    logic [DATA_BITS-1:0] shreg;
    logic                 par_bad;
    logic                 stop_bad;
    logic                 done;
    logic                 tick;
    logic                 start_edge;
    logic                 sample_en;
    logic                 bit_val;
    logic                 frame_ok;
    logic                 load;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
            rx_prev <= rx_s;
        end
    end

    assign tick       = (div_cnt == DIV_LAST);
    assign start_edge = (state == S_IDLE) && rx_prev && !rx_s;

    // Both counters restart on the start edge so every frame gets its own sampling phase.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_cnt <= '0;
            os_cnt  <= '0;
        end else if (start_edge) begin
            div_cnt <= '0;
            os_cnt  <= '0;
        end else if (tick) begin
            div_cnt <= '0;
            os_cnt  <= (os_cnt == OS_LAST) ? '0 : os_cnt + OS_W'(1);
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

`ifdef UART_RX_MAJORITY_EN
    localparam logic [OS_W-1:0] PRE_IDX    = OS_W'(OVERSAMPLE / 2 - 1);
    localparam logic [OS_W-1:0] DECIDE_IDX = OS_W'(OVERSAMPLE / 2 + 1);

    logic [1:0] maj_hist;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            maj_hist <= '0;
        end else if (tick) begin
            if (os_cnt == PRE_IDX) maj_hist[0] <= rx_s;
            if (os_cnt == SAMPLE_IDX) maj_hist[1] <= rx_s;
        end
    end

    assign sample_en = tick && (os_cnt == DECIDE_IDX);
    assign bit_val   = (maj_hist[0] & maj_hist[1]) | (maj_hist[0] & rx_s) | (maj_hist[1] & rx_s);
`else
    assign sample_en = tick && (os_cnt == SAMPLE_IDX);
    assign bit_val   = rx_s;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= S_IDLE;
            bit_cnt  <= '0;
            shreg    <= '0;
            par_bad  <= 1'b0;
            stop_bad <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start_edge) state <= S_START;
                end
                S_START: begin
                    if (sample_en) begin
                        state   <= bit_val ? S_IDLE : S_DATA;
                        bit_cnt <= '0;
                    end
                end
                S_DATA: begin
                    if (sample_en) begin
                        shreg <= {bit_val, shreg[DATA_BITS-1:1]};
                        if (bit_cnt == LAST_DATA) begin
                            bit_cnt  <= '0;
                            par_bad  <= 1'b0;
                            stop_bad <= 1'b0;
                            state    <= (PARITY != 0) ? S_PARITY : S_STOP;
                        end else begin
                            bit_cnt <= bit_cnt + 4'd1;
                        end
                    end
                end
                S_PARITY: begin
                    if (sample_en) begin
                        par_bad <= (^shreg) ^ bit_val ^ PAR_ODD;
                        state   <= S_STOP;
                    end
                end
                S_STOP: begin
                    // Leave at the last stop sample so a back-to-back start edge is not missed.
                    if (sample_en) begin
                        stop_bad <= stop_bad | !bit_val;
                        if (bit_cnt == LAST_STOP) begin
                            bit_cnt <= '0;
                            done    <= 1'b1;
                            state   <= S_IDLE;
                        end else begin
                            bit_cnt <= bit_cnt + 4'd1;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign frame_ok = done && !stop_bad && !par_bad;
    assign load     = frame_ok && !(valid && !ready);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_out    <= '0;
            valid       <= 1'b0;
            rts         <= 1'b0;
            frame_err   <= 1'b0;
            parity_err  <= 1'b0;
            overrun_err <= 1'b0;
        end else begin
            frame_err   <= done && stop_bad;
            parity_err  <= done && !stop_bad && par_bad;
            overrun_err <= frame_ok && valid && !ready;
            rts         <= valid && !ready;
            if (load) begin
                data_out <= shreg;
                valid    <= 1'b1;
            end else if (valid && ready) begin
                valid <= 1'b0;
            end
        end
    end

    assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_uart_rx_param.sv
// tb/tb_uart_rx_param.sv - randomized and directed bench for uart_rx_param (8N1 and 8E1 instances)
module tb_uart_rx_param;

    localparam int BIT    = 160;
    localparam int K_FE   = 1;
    localparam int K_PE   = 2;
    localparam int K_GOOD = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset_n;
    logic       rx_l    [2];
    logic       ready_l [2];
    logic [7:0] dout_l  [2];
    logic       valid_l [2];
    logic       rts_l   [2];
    logic       busy_l  [2];
    logic       fe_l    [2];
    logic       pe_l    [2];
    logic       ov_l    [2];

    uart_rx_param #(
        .CLK_FREQ(18432000), .BAUD_RATE(115200), .OVERSAMPLE(16),
        .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)
    ) dut_n (
        .clk(clk), .reset_n(reset_n), .rx(rx_l[0]), .data_out(dout_l[0]),
        .valid(valid_l[0]), .ready(ready_l[0]), .rts(rts_l[0]), .busy(busy_l[0]),
        .frame_err(fe_l[0]), .parity_err(pe_l[0]), .overrun_err(ov_l[0])
    );

    uart_rx_param #(
        .CLK_FREQ(18432000), .BAUD_RATE(115200), .OVERSAMPLE(16),
        .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)
    ) dut_e (
        .clk(clk), .reset_n(reset_n), .rx(rx_l[1]), .data_out(dout_l[1]),
        .valid(valid_l[1]), .ready(ready_l[1]), .rts(rts_l[1]), .busy(busy_l[1]),
        .frame_err(fe_l[1]), .parity_err(pe_l[1]), .overrun_err(ov_l[1])
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    // Expected frame outcomes, pushed by the stimulus at the start of each stop bit.
    int         rk    [2][32];
    logic [7:0] rdat  [2][32];
    int         rlo   [2][32];
    int         rhi   [2][32];
    int         rtail [2] = '{0, 0};
    int         rhead [2] = '{0, 0};

    int q_sel [128];
    int q_id  [128];
    int q_exp [128];
    int q_n    = 0;
    int q_done = 0;

    // Holding-register model: occupancy and word, advanced by handshake rules.
    logic       mv    [2] = '{1'b0, 1'b0};
    logic [7:0] md    [2] = '{8'h00, 8'h00};
    logic       rdy_p [2] = '{1'b0, 1'b0};

    always @(negedge clk) begin
        logic        pend, trig, e_fe, e_pe, e_ov, nv;
        logic [7:0]  nd;
        logic [12:0] gv, ev;
        int          slot, got;
        for (int id = 0; id < 2; id++) begin
            if (!reset_n) begin
                total++;
                if ({valid_l[id], rts_l[id], busy_l[id], fe_l[id], pe_l[id], ov_l[id], dout_l[id]} !== 14'b0) begin
                    bad++;
                    $display("FAIL reset_vals dut%0d got=%b want=0", id,
                             {valid_l[id], rts_l[id], busy_l[id], fe_l[id], pe_l[id], ov_l[id], dout_l[id]});
                end
                mv[id]    = 1'b0;
                md[id]    = 8'h00;
                rhead[id] = rtail[id];
            end else begin
                pend = (rhead[id] != rtail[id]);
                slot = rhead[id] % 32;
                e_fe = 1'b0;
                e_pe = 1'b0;
                e_ov = 1'b0;
                nv   = mv[id] && !rdy_p[id];
                nd   = md[id];
                trig = fe_l[id] | pe_l[id] | ov_l[id] | (valid_l[id] && (!mv[id] || rdy_p[id]));
                if (trig) begin
                    if (pend && cyc >= rlo[id][slot] && cyc <= rhi[id][slot]) begin
                        case (rk[id][slot])
                            K_FE: e_fe = 1'b1;
                            K_PE: e_pe = 1'b1;
                            default: begin
                                if (mv[id] && !rdy_p[id]) begin
                                    e_ov = 1'b1;
                                end else begin
                                    nv = 1'b1;
                                    nd = rdat[id][slot];
                                end
                            end
                        endcase
                        rhead[id]++;
                    end else begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_event dut%0d cyc=%0d got fe,pe,ov,valid=%b%b%b%b want none",
                                 id, cyc, fe_l[id], pe_l[id], ov_l[id], valid_l[id]);
                    end
                end else if (pend && cyc > rhi[id][slot]) begin
                    total++;
                    bad++;
                    $display("FAIL completion_timeout dut%0d cyc=%0d got no event want kind=%0d",
                             id, cyc, rk[id][slot]);
                    rhead[id]++;
                end
                ev = {nv, mv[id] && !rdy_p[id], e_fe, e_pe, e_ov, nv ? nd : 8'h00};
                gv = {valid_l[id], rts_l[id], fe_l[id], pe_l[id], ov_l[id], nv ? dout_l[id] : 8'h00};
                total++;
                if (gv !== ev) begin
                    bad++;
                    $display("FAIL outputs dut%0d cyc=%0d got valid,rts,fe,pe,ov,data=%b want %b", id, cyc, gv, ev);
                end
                mv[id] = nv;
                md[id] = nd;
            end
            rdy_p[id] = ready_l[id];
        end
        while (q_done < q_n) begin
            slot = q_done % 128;
            case (q_sel[slot])
                0:       got = int'(busy_l[q_id[slot]]);
                1:       got = int'(valid_l[q_id[slot]]);
                2:       got = int'(dout_l[q_id[slot]]);
                default: got = int'(rts_l[q_id[slot]]);
            endcase
            total++;
            if (got != q_exp[slot]) begin
                bad++;
                $display("FAIL pin_sel%0d dut%0d cyc=%0d got=%0h want=%0h", q_sel[slot], q_id[slot], cyc, got, q_exp[slot]);
            end
            q_done++;
        end
    end

    task automatic hold(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic req(input int sel, input int id, input int exp);
        q_sel[q_n % 128] = sel;
        q_id[q_n % 128]  = id;
        q_exp[q_n % 128] = exp;
        q_n++;
    endtask

    // pmode: 0 = no parity bit, 2 = even; gl_bit >= 0 inverts that data bit for gl_len clk near mid-bit.
    task automatic send_frame(input int id, input logic [7:0] data, input int pmode, input logic pbit,
                              input logic stop_v, input int gl_bit, input int gl_len, input int gap);
        int kind;
        rx_l[id] = 1'b0;
        hold(BIT);
        req(0, id, 1);
        for (int i = 0; i < 8; i++) begin
            rx_l[id] = data[i];
            if (gl_bit == i) begin
                hold(88);
                rx_l[id] = ~data[i];
                hold(gl_len);
                rx_l[id] = data[i];
                hold(BIT - 88 - gl_len);
            end else begin
                hold(BIT);
            end
        end
        if (pmode != 0) begin
            rx_l[id] = pbit;
            hold(BIT);
        end
        if (!stop_v)
            kind = K_FE;
        else if (pmode == 2 && (($countones(data) + int'(pbit)) % 2) != 0)
            kind = K_PE;
        else
            kind = K_GOOD;
        rx_l[id] = stop_v;
        req(0, id, 1);
        rk[id][rtail[id] % 32]   = kind;
        rdat[id][rtail[id] % 32] = data;
        rlo[id][rtail[id] % 32]  = cyc + 40;
        rhi[id][rtail[id] % 32]  = cyc + 150;
        rtail[id]++;
        hold(BIT);
        rx_l[id] = 1'b1;
        if (gap > 0) hold(gap);
    endtask

    initial begin
        logic [7:0] d;
        logic       sv, pb;
        int         gp;
        reset_n    = 1'b0;
        rx_l[0]    = 1'b1;
        rx_l[1]    = 1'b1;
        ready_l[0] = 1'b1;
        ready_l[1] = 1'b1;
        @(posedge clk);
        #1;
        hold(4);
        reset_n = 1'b1;
        hold(20);

        send_frame(0, 8'hA5, 0, 1'b0, 1'b1, -1, 0, 40);
        req(0, 0, 0);
        req(1, 0, 0);

        ready_l[0] = 1'b0;
        send_frame(0, 8'h3C, 0, 1'b0, 1'b1, -1, 0, 0);
        send_frame(0, 8'h81, 0, 1'b0, 1'b1, -1, 0, 40);
        req(2, 0, 8'h3C);
        req(1, 0, 1);
        req(3, 0, 1);
        ready_l[0] = 1'b1;
        hold(2);
        req(1, 0, 0);
        req(3, 0, 0);

        send_frame(1, 8'h07, 2, 1'b0, 1'b1, -1, 0, 40);
        req(1, 1, 0);
        ready_l[1] = 1'b0;
        send_frame(1, 8'h07, 2, 1'b1, 1'b1, -1, 0, 40);
        req(2, 1, 8'h07);
        req(1, 1, 1);
        ready_l[1] = 1'b1;
        hold(4);

        send_frame(0, 8'h55, 0, 1'b0, 1'b0, -1, 0, 40);
        req(1, 0, 0);
        ready_l[0] = 1'b0;
        send_frame(0, 8'h55, 0, 1'b0, 1'b1, -1, 0, 40);
        req(2, 0, 8'h55);
        ready_l[0] = 1'b1;
        hold(4);

        rx_l[0] = 1'b0;
        hold(40);
        req(0, 0, 1);
        rx_l[0] = 1'b1;
        hold(400);
        req(0, 0, 0);
        req(1, 0, 0);

`ifdef UART_RX_MAJORITY_EN
        ready_l[0] = 1'b0;
        send_frame(0, 8'h5A, 0, 1'b0, 1'b1, 3, 10, 40);
        req(2, 0, 8'h5A);
        ready_l[0] = 1'b1;
        hold(4);
`endif

        rx_l[0] = 1'b0;
        hold(3 * BIT + 80);
        reset_n = 1'b0;
        rx_l[0] = 1'b1;
        hold(1);
        req(0, 0, 0);
        req(1, 0, 0);
        hold(3);
        reset_n = 1'b1;
        hold(50);
        ready_l[0] = 1'b0;
        send_frame(0, 8'h0F, 0, 1'b0, 1'b1, -1, 0, 40);
        req(2, 0, 8'h0F);
        ready_l[0] = 1'b1;
        hold(4);

        for (int n = 0; n < 12; n++) begin
            d  = 8'($urandom);
            sv = ($urandom_range(0, 7) != 0);
            gp = $urandom_range(0, 1) * $urandom_range(0, 200);
            if (!sv && gp < 40) gp = 40;
            ready_l[0] = 1'($urandom_range(0, 1));
            send_frame(0, d, 0, 1'b0, sv, -1, 0, gp);
        end
        ready_l[0] = 1'b1;

        for (int n = 0; n < 6; n++) begin
            d  = 8'($urandom);
            pb = 1'(($countones(d) + (($urandom_range(0, 3) == 0) ? 1 : 0)) % 2);
            ready_l[1] = 1'($urandom_range(0, 1));
            send_frame(1, d, 2, pb, 1'b1, -1, 0, 40);
        end
        ready_l[1] = 1'b1;

        hold(300);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
